// File: rtl/id_ex_stage.sv
// ID stage of the 4-stage pipeline: decode, register-file read with EX/WB forwarding,
// and the ID/EX pipeline register feeding the ALU. Also owns the 8x8 register file.
module id_ex_stage #(
  parameter int DATA_W = 8,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        instr_ID,
  input  logic [7:0]        PC_ID,
  input  logic              valid_ID,
  input  logic              flush,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              wb_en,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] A_in_EX,
  output logic [DATA_W-1:0] Imm_Data_EX,
  output logic [DATA_W-1:0] Sht_Data_EX,
  output logic [7:0]        PC_EX,
  output logic [1:0]        opcode_EX,
  output logic [3:0]        ControlLines,
  output logic              sht_imm,
  output logic [2:0]        rd_EX,
  output logic              regwrite_EX,
  output logic              valid_EX
);

  localparam logic [1:0] OP_MOVI = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SLL  = 2'b10;
  localparam logic [1:0] OP_JMP  = 2'b11;

  logic [DATA_W-1:0] r_regs [NREG];

  logic [1:0]        w_opcode;
  logic [2:0]        w_rd_addr;
  logic [2:0]        w_rs_addr;
  logic [DATA_W-1:0] w_rd_val;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_sht;
  logic [3:0]        w_ctrl;
  logic              w_sht_imm;
  logic              w_regwrite;
  logic              w_ex_fwd_ok;
  logic              w_load;

  assign w_opcode  = instr_ID[7:6];
  assign w_rd_addr = instr_ID[5:3];
  assign w_rs_addr = instr_ID[2:0];

  // A bubble in EX has valid_EX=0 and regwrite_EX=0, so it can never forward.
  assign w_ex_fwd_ok = valid_EX & regwrite_EX;

  // Operand priority: EX result, then same-cycle WB write, then the register file.
  always_comb begin
    w_rd_val = r_regs[w_rd_addr];
    if (w_ex_fwd_ok && (rd_EX == w_rd_addr)) begin
      w_rd_val = ex_result;
    end else if (wb_en && (wb_addr == w_rd_addr)) begin
      w_rd_val = wb_data;
    end

    w_rs_val = r_regs[w_rs_addr];
    if (w_ex_fwd_ok && (rd_EX == w_rs_addr)) begin
      w_rs_val = ex_result;
    end else if (wb_en && (wb_addr == w_rs_addr)) begin
      w_rs_val = wb_data;
    end
  end

  always_comb begin
    w_imm      = '0;
    w_sht      = '0;
    w_ctrl     = 4'b0010;
    w_sht_imm  = 1'b0;
    w_regwrite = 1'b1;
    case (w_opcode)
      OP_MOVI: w_imm = {5'b0, instr_ID[2:0]};
      OP_ADD:  w_imm = w_rs_val;
      OP_SLL: begin
        w_sht     = {5'b0, instr_ID[2:0]};
        w_ctrl    = 4'b1000;
        w_sht_imm = 1'b1;
      end
      OP_JMP: begin
        w_imm      = {{2{instr_ID[5]}}, instr_ID[5:0]};
        w_regwrite = 1'b0;
      end
      default: w_imm = '0;
    endcase
  end

  // valid_ID qualifies instr_ID; flush squashes it. Either way EX receives an all-zero bubble.
  assign w_load = valid_ID & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      A_in_EX      <= '0;
      Imm_Data_EX  <= '0;
      Sht_Data_EX  <= '0;
      PC_EX        <= '0;
      opcode_EX    <= '0;
      ControlLines <= '0;
      sht_imm      <= 1'b0;
      rd_EX        <= '0;
      regwrite_EX  <= 1'b0;
      valid_EX     <= 1'b0;
    end else begin
      if (wb_en) begin
        r_regs[wb_addr] <= wb_data;
      end
      if (w_load) begin
        A_in_EX      <= w_rd_val;
        Imm_Data_EX  <= w_imm;
        Sht_Data_EX  <= w_sht;
        PC_EX        <= PC_ID;
        opcode_EX    <= w_opcode;
        ControlLines <= w_ctrl;
        sht_imm      <= w_sht_imm;
        rd_EX        <= w_rd_addr;
        regwrite_EX  <= w_regwrite;
        valid_EX     <= 1'b1;
      end else begin
        A_in_EX      <= '0;
        Imm_Data_EX  <= '0;
        Sht_Data_EX  <= '0;
        PC_EX        <= '0;
        opcode_EX    <= '0;
        ControlLines <= '0;
        sht_imm      <= 1'b0;
        rd_EX        <= '0;
        regwrite_EX  <= 1'b0;
        valid_EX     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, forwarding priority, bubbles, flush and reset.
module tb_id_ex_stage;

  logic       clk;
  logic       reset;
  logic [7:0] instr_ID;
  logic [7:0] PC_ID;
  logic       valid_ID;
  logic       flush;
  logic [7:0] ex_result;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic [7:0] A_in_EX;
  logic [7:0] Imm_Data_EX;
  logic [7:0] Sht_Data_EX;
  logic [7:0] PC_EX;
  logic [1:0] opcode_EX;
  logic [3:0] ControlLines;
  logic       sht_imm;
  logic [2:0] rd_EX;
  logic       regwrite_EX;
  logic       valid_EX;

  int checks;
  int failures;

  id_ex_stage #(.DATA_W(8), .NREG(8)) dut (
    .clk(clk), .reset(reset), .instr_ID(instr_ID), .PC_ID(PC_ID), .valid_ID(valid_ID),
    .flush(flush), .ex_result(ex_result), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .A_in_EX(A_in_EX), .Imm_Data_EX(Imm_Data_EX),
    .Sht_Data_EX(Sht_Data_EX), .PC_EX(PC_EX), .opcode_EX(opcode_EX),
    .ControlLines(ControlLines), .sht_imm(sht_imm), .rd_EX(rd_EX),
    .regwrite_EX(regwrite_EX), .valid_EX(valid_EX)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every EX output packed together, 44 bits.
  function automatic logic [63:0] all_outs();
    return {20'b0, A_in_EX, Imm_Data_EX, Sht_Data_EX, PC_EX, opcode_EX, ControlLines,
            sht_imm, rd_EX, regwrite_EX, valid_EX};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic [7:0] ins, input logic [7:0] pc, input logic v,
                          input logic fl);
    instr_ID = ins; PC_ID = pc; valid_ID = v; flush = fl;
  endtask

  task automatic drive_wb(input logic en, input logic [2:0] addr, input logic [7:0] data);
    wb_en = en; wb_addr = addr; wb_data = data;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; ex_result = 8'h00;
    drive_id(8'h00, 8'h00, 1'b0, 1'b0);
    drive_wb(1'b0, 3'd0, 8'h00);
    step();
    check("reset_outs", all_outs(), 64'h0);

    // Preload R3, then reset must clear it.
    reset = 1'b0;
    drive_wb(1'b1, 3'd3, 8'h55);
    step();
    reset = 1'b1;
    drive_wb(1'b0, 3'd0, 8'h00);
    drive_id(8'h5B, 8'h01, 1'b1, 1'b0);
    step();
    check("reset_mid_outs", all_outs(), 64'h0);
    reset = 1'b0;
    drive_id(8'h5B, 8'h02, 1'b1, 1'b0);  // ADD r3,r3
    step();
    check("add_r3_A", A_in_EX, 8'h00);
    check("add_r3_B", Imm_Data_EX, 8'h00);
    check("add_r3_ctrl", {ControlLines, sht_imm, rd_EX, regwrite_EX, valid_EX},
          {4'b0010, 1'b0, 3'd3, 1'b1, 1'b1});
    check("add_r3_pc", PC_EX, 8'h02);

    // MOVI r2,5
    drive_id(8'h15, 8'h03, 1'b1, 1'b0);
    step();
    check("movi_imm", Imm_Data_EX, 8'h05);
    check("movi_ctl", {opcode_EX, rd_EX, regwrite_EX, Sht_Data_EX},
          {2'b00, 3'd2, 1'b1, 8'h00});

    // Bubble in ID while WB writes R2=5
    drive_id(8'h00, 8'h00, 1'b0, 1'b0);
    drive_wb(1'b1, 3'd2, 8'h05);
    step();
    check("bubble_outs", all_outs(), 64'h0);

    // ADD r1,r2 reads R2 from the register file
    drive_wb(1'b0, 3'd0, 8'h00);
    drive_id(8'h4A, 8'h04, 1'b1, 1'b0);
    step();
    check("rf_read_B", Imm_Data_EX, 8'h05);
    check("rf_read_ctl", {ControlLines, sht_imm, Sht_Data_EX, A_in_EX},
          {4'b0010, 1'b0, 8'h00, 8'h00});

    // EX forward beats a same-cycle WB write of R1
    ex_result = 8'h0A;
    drive_wb(1'b1, 3'd1, 8'h77);
    drive_id(8'h61, 8'h05, 1'b1, 1'b0);  // ADD r4,r1
    step();
    check("ex_fwd_B", Imm_Data_EX, 8'h0A);
    check("ex_fwd_A", A_in_EX, 8'h00);

    // WB bypass for SLL r6,2 (EX holds ADD r4, which does not match)
    ex_result = 8'h99;
    drive_wb(1'b1, 3'd6, 8'h3C);
    drive_id(8'hB2, 8'h06, 1'b1, 1'b0);
    step();
    check("wb_byp_A", A_in_EX, 8'h3C);
    check("sll_sht", Sht_Data_EX, 8'h02);
    check("sll_ctl", {Imm_Data_EX, ControlLines, sht_imm, opcode_EX, rd_EX, regwrite_EX},
          {8'h00, 4'b1000, 1'b1, 2'b10, 3'd6, 1'b1});

    // JMP with negative offset
    drive_wb(1'b0, 3'd0, 8'h00);
    drive_id(8'hFE, 8'h10, 1'b1, 1'b0);
    step();
    check("jmp_neg_imm", Imm_Data_EX, 8'hFE);
    check("jmp_neg_ctl", {opcode_EX, PC_EX, regwrite_EX, valid_EX, Sht_Data_EX, ControlLines},
          {2'b11, 8'h10, 1'b0, 1'b1, 8'h00, 4'b0010});

    // JMP with positive offset (bit 5 clear)
    drive_id(8'hC5, 8'h20, 1'b1, 1'b0);
    step();
    check("jmp_pos_imm", Imm_Data_EX, 8'h05);
    drive_id(8'hE0, 8'h21, 1'b1, 1'b0);
    step();
    check("jmp_min_imm", Imm_Data_EX, 8'hE0);

    // Flush squashes a valid ADD r5,r1
    ex_result = 8'hAB;
    drive_id(8'h69, 8'h30, 1'b1, 1'b1);
    step();
    check("flush_outs", all_outs(), 64'h0);

    // The flushed bubble (rd_EX=0) must not forward ex_result into ADD r0,r0
    drive_id(8'h40, 8'h31, 1'b1, 1'b0);
    step();
    check("no_fwd_bubble", {A_in_EX, Imm_Data_EX}, 16'h0000);

    // ADD r1,r1 sees R1=0x77 committed earlier (EX holds r0, no match)
    drive_id(8'h49, 8'h32, 1'b1, 1'b0);
    step();
    check("rf_r1", {A_in_EX, Imm_Data_EX}, 16'h7777);

    // Reset overrides a WB write and a valid instruction
    reset = 1'b1;
    drive_wb(1'b1, 3'd2, 8'hEE);
    drive_id(8'h52, 8'h33, 1'b1, 1'b0);
    step();
    check("reset_override", all_outs(), 64'h0);
    reset = 1'b0;
    drive_wb(1'b0, 3'd0, 8'h00);
    drive_id(8'h52, 8'h34, 1'b1, 1'b0);  // ADD r2,r2
    step();
    check("reset_no_wb", {A_in_EX, Imm_Data_EX}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
